// File: rtl/uart_bus_responder.sv
// Purpose : chip-side UART endpoint on the rdn/wrn/data bus; 8N1 serialiser on txd, deserialiser on rxd.
// Latency : write commits 3 clk after raw wrn rises, start bit 1 clk later; rx byte visible at the stop sample.
// Backpr. : tbre=0 means the holding register is full; a write in that state is dropped with overrun_err.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rdn, wrn, data    active-low read/write strobes and shared 8-bit bus (driven only while rdn=0)
//   data_ready        receive buffer holds an unread byte
//   tbre, tsre        transmit holding / shift register empty
//   rxd, txd          serial in / out, idle high
//   overrun_err       one-cycle pulse when a byte is lost (tx or rx side)
//   frame_err         one-cycle pulse when a received stop bit is 0
module uart_bus_responder #(
    parameter int unsigned CLKS_PER_BIT = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdn,
    input  logic       wrn,
    inout  wire  [7:0] data,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    input  logic       rxd,
    output logic       txd,
    output logic       overrun_err,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ------------------------------------------------------------------
    // Synchronisers: bit 1 is the synchronised copy, bit 2 its previous
    // value for edge detection. Idle level of all three inputs is high.
    // ------------------------------------------------------------------
    logic [2:0] r_rdn_sync;
    logic [2:0] r_wrn_sync;
    logic [2:0] r_rxd_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdn_sync <= 3'b111;
            r_wrn_sync <= 3'b111;
            r_rxd_sync <= 3'b111;
        end else begin
            r_rdn_sync <= {r_rdn_sync[1:0], rdn};
            r_wrn_sync <= {r_wrn_sync[1:0], wrn};
            r_rxd_sync <= {r_rxd_sync[1:0], rxd};
        end
    end

    logic w_rdn_rise;
    logic w_wrn_rise;
    logic w_rxd_fall;
    logic w_rxd;

    assign w_rdn_rise = r_rdn_sync[1] & ~r_rdn_sync[2];
    assign w_wrn_rise = r_wrn_sync[1] & ~r_wrn_sync[2];
    assign w_rxd_fall = ~r_rxd_sync[1] & r_rxd_sync[2];
    assign w_rxd      = r_rxd_sync[1];

    // ------------------------------------------------------------------
    // Bus side
    // ------------------------------------------------------------------
    logic [7:0] r_rbr;
    logic [7:0] r_thr;
    logic [7:0] r_wr_shadow;
    logic       r_tbre;

    // Read data follows raw rdn so the controller sees it without sync delay.
    assign data = rdn ? 8'hzz : r_rbr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_shadow <= 8'h00;
        end else if (!r_wrn_sync[1]) begin
            r_wr_shadow <= data;
        end
    end

    logic w_commit;
    logic w_tx_ovr;

    assign w_commit = w_wrn_rise & r_tbre;
    assign w_tx_ovr = w_wrn_rise & ~r_tbre;

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t        r_tx_state, w_tx_state_nxt;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]       r_tx_idx, w_tx_idx_nxt;
    logic [7:0]       r_tsr;
    logic             r_tsre;
    logic             w_tx_load;
    logic             w_tx_done;
    logic             w_txd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_idx   <= 3'd0;
            r_tsr      <= 8'h00;
            r_thr      <= 8'h00;
            r_tbre     <= 1'b1;
            r_tsre     <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            if (w_tx_load) begin
                r_tsr <= r_thr;
            end
            if (w_commit) begin
                r_thr <= r_wr_shadow;
            end
            // Commit needs tbre=1 and load needs tbre=0, so they never coincide.
            if (w_tx_load) begin
                r_tbre <= 1'b1;
            end else if (w_commit) begin
                r_tbre <= 1'b0;
            end
            if (w_tx_load) begin
                r_tsre <= 1'b0;
            end else if (w_tx_done) begin
                r_tsre <= 1'b1;
            end
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CNT_ONE;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_load      = 1'b0;
        w_tx_done      = 1'b0;
        w_txd          = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                if (!r_tbre) begin
                    w_tx_load      = 1'b1;
                    w_tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                w_txd = 1'b0;
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_idx_nxt   = 3'd0;
                    w_tx_state_nxt = TX_DATA;
                end
            end
            TX_DATA: begin
                w_txd = r_tsr[r_tx_idx];
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_idx == 3'd7) begin
                        w_tx_idx_nxt   = 3'd0;
                        w_tx_state_nxt = TX_STOP;
                    end else begin
                        w_tx_idx_nxt = r_tx_idx + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                w_txd = 1'b1;
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nxt = '0;
                    // A pending byte chains straight into the next start bit.
                    if (!r_tbre) begin
                        w_tx_load      = 1'b1;
                        w_tx_state_nxt = TX_START;
                    end else begin
                        w_tx_done      = 1'b1;
                        w_tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    rx_state_t        r_rx_state, w_rx_state_nxt;
    logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
    logic [2:0]       r_rx_idx, w_rx_idx_nxt;
    logic [7:0]       r_rx_shift;
    logic             w_rx_shift;
    logic             w_rx_done;
    logic             w_rx_ferr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_idx   <= w_rx_idx_nxt;
            if (w_rx_shift) begin
                r_rx_shift <= {w_rxd, r_rx_shift[7:1]};
            end
        end
    end

    // The start bit is checked at mid-bit; every later sample is a full bit
    // time after the previous one, so data and stop are also sampled mid-bit.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + CNT_ONE;
        w_rx_idx_nxt   = r_rx_idx;
        w_rx_shift     = 1'b0;
        w_rx_done      = 1'b0;
        w_rx_ferr      = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (w_rxd_fall) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_rx_cnt == CNT_HALF) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_idx_nxt   = 3'd0;
                    w_rx_state_nxt = w_rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_shift   = 1'b1;
                    if (r_rx_idx == 3'd7) begin
                        w_rx_idx_nxt   = 3'd0;
                        w_rx_state_nxt = RX_STOP;
                    end else begin
                        w_rx_idx_nxt = r_rx_idx + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_IDLE;
                    if (w_rxd) begin
                        w_rx_done = 1'b1;
                    end else begin
                        w_rx_ferr = 1'b1;
                    end
                end
            end
            default: begin
                w_rx_state_nxt = RX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Receive buffer and status pulses
    // ------------------------------------------------------------------
    logic r_data_ready;
    logic r_overrun;
    logic r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rbr        <= 8'h00;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_rx_done) begin
                r_rbr <= r_rx_shift;
            end
            // A completed byte wins over a simultaneous read-clear.
            if (w_rx_done) begin
                r_data_ready <= 1'b1;
            end else if (w_rdn_rise) begin
                r_data_ready <= 1'b0;
            end
            r_overrun   <= w_tx_ovr | (w_rx_done & r_data_ready);
            r_frame_err <= w_rx_ferr;
        end
    end

    assign data_ready  = r_data_ready;
    assign tbre        = r_tbre;
    assign tsre        = r_tsre;
    assign txd         = w_txd;
    assign overrun_err = r_overrun;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Bench for uart_bus_responder: directed scenario sequence with random bytes
// and gaps, checked against a frame-level timing model of the UART.
module tb_uart_bus_responder;

    localparam int BIT   = 96;
    localparam int FRAME = 10 * BIT;

    logic       clk;
    logic       rst;
    logic       rdn;
    logic       wrn;
    logic       rxd;
    wire  [7:0] data;
    logic       data_ready;
    logic       tbre;
    logic       tsre;
    logic       txd;
    logic       overrun_err;
    logic       frame_err;

    logic [7:0] tb_dat;
    logic       tb_drv;
    assign data = tb_drv ? tb_dat : 8'hzz;

    uart_bus_responder #(.CLKS_PER_BIT(BIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdn         (rdn),
        .wrn         (wrn),
        .data        (data),
        .data_ready  (data_ready),
        .tbre        (tbre),
        .tsre        (tsre),
        .rxd         (rxd),
        .txd         (txd),
        .overrun_err (overrun_err),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: frame-level transmitter timing and receive buffer.
    int         m_sh_end     = 0;   // edge at which the current frame's stop bit ends
    int         m_hold_start = -1;  // start edge of the byte last placed in the holding register
    logic [7:0] m_rbr        = 8'h00;
    logic       m_dr         = 1'b0;
    int         exp_byte[$];
    int         exp_start[$];

    // txd monitor results
    int mon_byte[$];
    int mon_start[$];
    int mon_ok[$];

    // pulse counters used while driving rx frames
    bit cnt_en  = 1'b0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    always @(negedge clk) begin
        if (cnt_en) begin
            ferr_cnt += int'(frame_err);
            ovr_cnt  += int'(overrun_err);
        end
    end

    initial begin : txmon
        logic [7:0] mb;
        int         ms;
        int         mok;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                ms = cyc;
                repeat (BIT / 2) @(negedge clk);
                mok = (txd === 1'b0) ? 1 : 0;
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    mb[i] = txd;
                end
                repeat (BIT) @(negedge clk);
                if (txd !== 1'b1) mok = 0;
                mon_byte.push_back(int'(mb));
                mon_start.push_back(ms);
                mon_ok.push_back(mok);
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int target, input string tag);
        int g = 0;
        while (cyc < target && g < 20000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk(tag, 32'(cyc >= target), 32'd1);
    endtask

    task automatic bus_write(input logic [7:0] b);
        int c;
        int s;
        @(negedge clk);
        tb_dat = b;
        tb_drv = 1'b1;
        wrn    = 1'b0;
        repeat (4) @(negedge clk);
        wrn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        c = cyc + 1;
        chk("wr_tbre_before", 32'(tbre), 32'(c > m_hold_start));
        @(posedge clk);
        #1;
        c = cyc;
        if (c > m_hold_start) begin
            s = (c + 1 > m_sh_end) ? c + 1 : m_sh_end;
            m_sh_end     = s + FRAME;
            m_hold_start = s;
            exp_byte.push_back(int'(b));
            exp_start.push_back(s);
            chk("wr_tbre_clr", 32'(tbre), 32'd0);
            chk("wr_no_ovr", 32'(overrun_err), 32'd0);
            if (s == c + 1) begin
                @(posedge clk);
                #1;
                chk("wr_tbre_reload", 32'(tbre), 32'd1);
                chk("wr_tsre_busy", 32'(tsre), 32'd0);
                chk("wr_txd_start", 32'(txd), 32'd0);
            end
        end else begin
            chk("wr_ovr", 32'(overrun_err), 32'd1);
            chk("wr_tbre_full", 32'(tbre), 32'd0);
            @(posedge clk);
            #1;
            chk("wr_ovr_end", 32'(overrun_err), 32'd0);
        end
        @(negedge clk);
        tb_drv = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] exp);
        @(negedge clk);
        rdn = 1'b0;
        @(negedge clk);
        chk("rd_data", 32'(data), 32'(exp));
        rdn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rd_dr_hold", 32'(data_ready), 32'(m_dr));
        @(posedge clk);
        #1;
        chk("rd_dr_clr", 32'(data_ready), 32'd0);
        m_dr = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        int exp_ovr;
        int exp_ferr;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        cnt_en   = 1'b1;
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        chk("rx_dr_before_stop", 32'(data_ready), 32'(m_dr));
        rxd = stop;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        cnt_en = 1'b0;
        if (stop) begin
            exp_ovr  = int'(m_dr);
            exp_ferr = 0;
            m_rbr    = b;
            m_dr     = 1'b1;
        end else begin
            exp_ovr  = 0;
            exp_ferr = 1;
        end
        chk("rx_ferr_pulses", 32'(ferr_cnt), 32'(exp_ferr));
        chk("rx_ovr_pulses", 32'(ovr_cnt), 32'(exp_ovr));
        chk("rx_dr_after", 32'(data_ready), 32'(m_dr));
    endtask

    task automatic tx_drain();
        int n;
        wait_cyc(m_sh_end + 60, "tx_drain_bound");
        chk("tx_frame_count", 32'(mon_byte.size()), 32'(exp_byte.size()));
        n = (mon_byte.size() < exp_byte.size()) ? mon_byte.size() : exp_byte.size();
        for (int i = 0; i < n; i++) begin
            chk("tx_byte", 32'(mon_byte[i]), 32'(exp_byte[i]));
            chk("tx_start_cyc", 32'(mon_start[i]), 32'(exp_start[i]));
            chk("tx_framing", 32'(mon_ok[i]), 32'd1);
        end
        mon_byte.delete();
        mon_start.delete();
        mon_ok.delete();
        exp_byte.delete();
        exp_start.delete();
    endtask

    initial begin : stim
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        rst    = 1'b1;
        rdn    = 1'b1;
        wrn    = 1'b1;
        rxd    = 1'b1;
        tb_dat = 8'h00;
        tb_drv = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_tbre", 32'(tbre), 32'd1);
        chk("rst_tsre", 32'(tsre), 32'd1);
        chk("rst_data_ready", 32'(data_ready), 32'd0);
        chk("rst_overrun", 32'(overrun_err), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tb_dat = 8'h5A;
        tb_drv = 1'b1;
        #1;
        chk("bus_released", 32'(data), 32'h5A);
        @(negedge clk);
        tb_drv = 1'b0;
        bus_read(8'h00);

        // single write, bit timing on txd
        bus_write(8'hA5);
        tx_drain();

        // receive and read back
        rx_frame(8'h3C, 1'b1);
        bus_read(8'h3C);

        // back-to-back frames and a dropped third write
        bus_write(8'h11);
        repeat (10) @(negedge clk);
        bus_write(8'h22);
        bus_write(8'h33);
        tx_drain();

        // frame error leaves rbr alone; short glitch is ignored
        rx_frame(8'($urandom), 1'b0);
        bus_read(m_rbr);
        ferr_cnt = 0;
        cnt_en   = 1'b1;
        @(negedge clk);
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        repeat (200) @(negedge clk);
        cnt_en = 1'b0;
        chk("glitch_ferr", 32'(ferr_cnt), 32'd0);
        chk("glitch_dr", 32'(data_ready), 32'd0);
        r1 = 8'($urandom);
        rx_frame(r1, 1'b1);
        bus_read(r1);

        // receive overrun
        rx_frame(8'h01, 1'b1);
        rx_frame(8'h02, 1'b1);
        bus_read(8'h02);

        // random bytes and gaps
        for (int k = 0; k < 3; k++) begin
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            r3 = 8'($urandom);
            bus_write(r1);
            repeat ($urandom_range(5, 1400)) @(negedge clk);
            bus_write(r2);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            bus_write(r3);
            tx_drain();
            r1 = 8'($urandom);
            rx_frame(r1, 1'b1);
            bus_read(r1);
        end

        // asynchronous reset in the middle of a data bit
        bus_write(8'($urandom));
        wait_cyc(exp_start[0] + 3 * BIT + 40, "mid_bit_bound");
        #1;
        rst = 1'b1;
        #1;
        chk("arst_txd", 32'(txd), 32'd1);
        chk("arst_tsre", 32'(tsre), 32'd1);
        chk("arst_tbre", 32'(tbre), 32'd1);
        repeat (3) @(negedge clk);
        rst          = 1'b0;
        m_sh_end     = 0;
        m_hold_start = -1;
        m_rbr        = 8'h00;
        m_dr         = 1'b0;
        repeat (1100) @(negedge clk);
        mon_byte.delete();
        mon_start.delete();
        mon_ok.delete();
        exp_byte.delete();
        exp_start.delete();
        bus_write(8'($urandom));
        tx_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
